// File: rtl/line_buffer_param.sv
// line_buffer_param
// One image line of pixel storage. Each read returns a KERNEL_W-pixel
// horizontal window starting at the read pointer. The window is registered and
// comes with a valid strobe, line-status flags and wrap/replicate border handling.
// Valid/ready note: there is no back-pressure. i_data_valid writes a pixel in
// the cycle it is high. rd_data requests a window in the cycle it is high, and
// o_data_valid follows exactly one cycle later.
module line_buffer_param #(
  parameter int PIXEL_W     = 8,
  parameter int IMAGE_WIDTH = 512,
  parameter int KERNEL_W    = 3,
  parameter int BORDER_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PIXEL_W-1:0]          i_data,
  input  logic                        i_data_valid,
  input  logic                        rd_data,
  output logic [KERNEL_W*PIXEL_W-1:0] o_data,
  output logic                        o_data_valid,
  output logic                        o_line_full,
  output logic                        o_overrun
);

  localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(IMAGE_WIDTH - 1);
  // Window arithmetic uses one extra bit so rd_ptr + tap never overflows.
  localparam logic [AW:0] WIDTH_X = (AW+1)'(IMAGE_WIDTH);
  localparam logic [AW:0] LAST_X  = (AW+1)'(IMAGE_WIDTH - 1);
  localparam logic [AW:0] HALF_X  = (AW+1)'(KERNEL_W / 2);

  logic [PIXEL_W-1:0]          mem_q [IMAGE_WIDTH];
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [KERNEL_W*PIXEL_W-1:0] o_data_q, o_data_d;
  logic                        o_data_valid_q, o_data_valid_d;
  logic                        line_full_q, line_full_d;
  logic                        overrun_q, overrun_d;
  logic                        wr_wrap, rd_wrap;
  logic [KERNEL_W*PIXEL_W-1:0] window;

  // Per-tap column address, then an asynchronous memory read.
  // Reads sample the array before this edge's write, so a same-column
  // read and write returns the old pixel.
  for (genvar k = 0; k < KERNEL_W; k++) begin : g_tap
    logic [AW:0]   sum;
    logic [AW-1:0] idx;
    assign sum = {1'b0, rd_ptr_q} + (AW+1)'(k);
    if (BORDER_MODE == 0) begin : g_wrap
      // sum < 2*IMAGE_WIDTH, so one conditional subtract gives the modulo.
      // The result is below IMAGE_WIDTH, so dropping the top bit is exact.
      assign idx = AW'((sum >= WIDTH_X) ? (sum - WIDTH_X) : sum);
    end else begin : g_repl
      // Clamp (sum - KERNEL_W/2) to [0, IMAGE_WIDTH-1]. The low side is
      // tested before subtracting, so the value never goes negative.
      assign idx = AW'((sum < HALF_X) ? '0 :
                       (((sum - HALF_X) > LAST_X) ? LAST_X : (sum - HALF_X)));
    end
    assign window[k*PIXEL_W +: PIXEL_W] = mem_q[idx];
  end

  // Pixel store. It has no reset, and writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (i_data_valid && !rst) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // Next-state logic: pointer advance with explicit wrap, line flags, output window.
  always_comb begin
    wr_wrap        = i_data_valid && (wr_ptr_q == LAST_PTR);
    rd_wrap        = rd_data && (rd_ptr_q == LAST_PTR);
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    o_data_d       = o_data_q;
    o_data_valid_d = rd_data;
    if (i_data_valid) begin
      wr_ptr_d = wr_wrap ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_data) begin
      rd_ptr_d = rd_wrap ? '0 : rd_ptr_q + AW'(1);
      o_data_d = window;
    end
    // A line written in the same cycle as the last read means a fresh line is ready.
    if (wr_wrap) begin
      line_full_d = 1'b1;
    end else if (rd_wrap) begin
      line_full_d = 1'b0;
    end else begin
      line_full_d = line_full_q;
    end
    overrun_d = wr_wrap && line_full_q && !rd_wrap;
  end

  // State and output registers, async active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      o_data_q       <= '0;
      o_data_valid_q <= 1'b0;
      line_full_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      o_data_q       <= o_data_d;
      o_data_valid_q <= o_data_valid_d;
      line_full_q    <= line_full_d;
      overrun_q      <= overrun_d;
    end
  end

  assign o_data       = o_data_q;
  assign o_data_valid = o_data_valid_q;
  assign o_line_full  = line_full_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_line_buffer_param.sv
// Testbench for line_buffer_param.
// dut_a uses the default parameters (512 wide, 3 taps, wrap).
// dut_b is 8 wide with replicate borders.
module tb_line_buffer_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [7:0]  a_din, b_din;
  logic        a_wv, a_rd, b_wv, b_rd;
  logic [23:0] a_dout, b_dout;
  logic        a_valid, a_full, a_ovr;
  logic        b_valid, b_full, b_ovr;

  line_buffer_param dut_a (
    .clk(clk), .rst(rst_a), .i_data(a_din), .i_data_valid(a_wv), .rd_data(a_rd),
    .o_data(a_dout), .o_data_valid(a_valid), .o_line_full(a_full), .o_overrun(a_ovr)
  );

  line_buffer_param #(.PIXEL_W(8), .IMAGE_WIDTH(8), .KERNEL_W(3), .BORDER_MODE(1)) dut_b (
    .clk(clk), .rst(rst_b), .i_data(b_din), .i_data_valid(b_wv), .rd_data(b_rd),
    .o_data(b_dout), .o_data_valid(b_valid), .o_line_full(b_full), .o_overrun(b_ovr)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int a_valid_cnt = 0;
  logic [23:0] exp_a_q[$];
  logic [23:0] exp_b_q[$];

  // Reference line for dut_a: pixel contents plus read/write column.
  logic [7:0] mdl_a [512];
  int mdl_rd = 0;
  int mdl_wr = 0;

  // Hand-computed replicate-border windows for the line 10..17.
  logic [23:0] b_table [8] = '{24'h111010, 24'h121110, 24'h131211, 24'h141312,
                               24'h151413, 24'h161514, 24'h171615, 24'h171716};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] win_a(input int r);
    return {mdl_a[(r + 2) % 512], mdl_a[(r + 1) % 512], mdl_a[r]};
  endfunction

  // ---------------- driver tasks ----------------
  // Each task starts 1 time unit after a rising edge and ends at the same point.
  task automatic a_cycle(input logic wv, input logic [7:0] d, input logic rd);
    if (rd) begin
      exp_a_q.push_back(win_a(mdl_rd));
      mdl_rd = (mdl_rd + 1) % 512;
    end
    if (wv) begin
      mdl_a[mdl_wr] = d;
      mdl_wr = (mdl_wr + 1) % 512;
    end
    a_wv = wv; a_din = d; a_rd = rd;
    @(posedge clk); #1;
    a_wv = 1'b0; a_rd = 1'b0;
  endtask

  task automatic b_cycle(input logic wv, input logic [7:0] d, input logic rd, input int r);
    if (rd) exp_b_q.push_back(b_table[r]);
    b_wv = wv; b_din = d; b_rd = rd;
    @(posedge clk); #1;
    b_wv = 1'b0; b_rd = 1'b0;
  endtask

  // ---------------- monitors ----------------
  // Pop one expected window per o_data_valid. Sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_a && a_valid) begin
      a_valid_cnt++;
      if (exp_a_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_unexpected_valid actual=%h expected=none", a_dout);
      end else begin
        check("a_window", 32'(a_dout), 32'(exp_a_q.pop_front()));
      end
    end
    if (!rst_b && b_valid) begin
      if (exp_b_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected_valid actual=%h expected=none", b_dout);
      end else begin
        check("b_window", 32'(b_dout), 32'(exp_b_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_din = '0; a_wv = 1'b0; a_rd = 1'b0;
    b_din = '0; b_wv = 1'b0; b_rd = 1'b0;
    for (int i = 0; i < 512; i++) mdl_a[i] = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    check("rst_a_data",  32'(a_dout),  32'h0);
    check("rst_a_valid", 32'(a_valid), 32'h0);
    check("rst_a_full",  32'(a_full),  32'h0);
    check("rst_a_ovr",   32'(a_ovr),   32'h0);
    check("rst_b_data",  32'(b_dout),  32'h0);
    check("rst_b_full",  32'(b_full),  32'h0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;

    // Full line 0..511, then 512 wrap-mode reads.
    for (int c = 0; c < 512; c++) begin
      a_cycle(1'b1, 8'(c), 1'b0);
      if (c == 510) check("full_after_511", 32'(a_full), 32'h0);
      if (c == 511) begin
        check("full_after_512", 32'(a_full), 32'h1);
        check("no_ovr_first",   32'(a_ovr),  32'h0);
      end
    end
    a_valid_cnt = 0;
    for (int r = 0; r < 512; r++) begin
      a_cycle(1'b0, 8'h00, 1'b1);
      if (r == 0)   check("rd_latency_1",   32'(a_valid), 32'h1);
      if (r == 510) check("full_before_end", 32'(a_full), 32'h1);
      if (r == 511) check("full_after_read", 32'(a_full), 32'h0);
    end
    a_cycle(1'b0, 8'h00, 1'b0);
    check("valid_drops",  32'(a_valid), 32'h0);
    check("valid_count",  32'(a_valid_cnt), 32'd512);
    check("data_holds",   32'(a_dout), 32'h0100FF);

    // Two lines without reads: overrun on the second wrap.
    for (int c = 0; c < 512; c++) a_cycle(1'b1, 8'(c) ^ 8'h5A, 1'b0);
    check("full_line1", 32'(a_full), 32'h1);
    for (int c = 0; c < 512; c++) begin
      a_cycle(1'b1, (c == 0) ? 8'hAA : 8'(c + 3), 1'b0);
      if (c == 510) check("ovr_not_early", 32'(a_ovr), 32'h0);
      if (c == 511) begin
        check("ovr_pulse",     32'(a_ovr),  32'h1);
        check("full_on_ovr",   32'(a_full), 32'h1);
      end
    end
    a_cycle(1'b0, 8'h00, 1'b0);
    check("ovr_one_cycle", 32'(a_ovr),  32'h0);
    check("full_stays",    32'(a_full), 32'h1);

    // Same-cycle write/read of column 0 returns the old pixel.
    a_cycle(1'b1, 8'h55, 1'b1);
    check("rbw_old_tap0", 32'(a_dout[7:0]), 32'hAA);
    for (int r = 1; r < 512; r++) a_cycle(1'b0, 8'h00, 1'b1);
    check("full_clr_line2", 32'(a_full), 32'h0);
    for (int c = 1; c < 512; c++) a_cycle(1'b1, 8'(c + 7), 1'b0);
    check("full_line3", 32'(a_full), 32'h1);
    check("no_ovr_line3", 32'(a_ovr), 32'h0);
    a_cycle(1'b0, 8'h00, 1'b1);
    check("new_tap0", 32'(a_dout[7:0]), 32'h55);

    // Reset in the middle of a line.
    for (int c = 0; c < 100; c++) a_cycle(1'b1, 8'(c + 8'h30), 1'b0);
    a_din = 8'hEE; a_wv = 1'b1;
    rst_a = 1'b1;
    #1;
    check("mid_rst_data",  32'(a_dout),  32'h0);
    check("mid_rst_valid", 32'(a_valid), 32'h0);
    check("mid_rst_full",  32'(a_full),  32'h0);
    check("mid_rst_ovr",   32'(a_ovr),   32'h0);
    @(posedge clk); #1;
    a_wv = 1'b0; rst_a = 1'b0;
    mdl_wr = 0; mdl_rd = 0;
    @(posedge clk); #1;
    a_cycle(1'b1, 8'hC3, 1'b0);
    check("post_rst_full", 32'(a_full), 32'h0);
    a_cycle(1'b0, 8'h00, 1'b1);
    check("post_rst_col0", 32'(a_dout), 32'h3231C3);

    // Replicate border, 8-wide line.
    for (int c = 0; c < 8; c++) b_cycle(1'b1, 8'(8'h10 + c), 1'b0, 0);
    check("b_full_set", 32'(b_full), 32'h1);
    for (int r = 0; r < 8; r++) b_cycle(1'b0, 8'h00, 1'b1, r);
    check("b_full_clr", 32'(b_full), 32'h0);
    check("b_ovr",      32'(b_ovr),  32'h0);

    @(posedge clk); @(posedge clk); #1;
    check("a_queue_empty", 32'(exp_a_q.size()), 32'h0);
    check("b_queue_empty", 32'(exp_b_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
